// File: rtl/kvs_pkg.sv
// kvs_pkg: key/value widths and update record shared by kvs and its front ends
package kvs_pkg;
  localparam int KEY_BITS = 8;
  localparam int VAL_BITS = 8;
  typedef logic [KEY_BITS-1:0] key_t;
  typedef logic [VAL_BITS-1:0] val_t;
  typedef struct packed {
    key_t key;
    val_t inc;
  } upd_t;
endpackage

// File: rtl/kvs_ins_fifo.sv
// kvs_ins_fifo: pending-insert queue of {key, inc} with per-entry valid/key taps for hazard compares
module kvs_ins_fifo
  import kvs_pkg::*;
#(
  parameter int KW    = KEY_BITS,
  parameter int VW    = VAL_BITS,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [KW-1:0]          key_i,
  input  logic [VW-1:0]          inc_i,
  input  logic                   pop_i,
  output logic [KW-1:0]          key_o,
  output logic [VW-1:0]          inc_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] cnt_o,
  output logic [DEPTH-1:0]       ent_vld_o,
  output logic [KW-1:0]          ent_key_o [DEPTH]
);
  localparam int AW = $clog2(DEPTH);
  logic [KW-1:0]    key_q [DEPTH];
  logic [VW-1:0]    inc_q [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [AW-1:0]    wp_q, rp_q;
  logic [AW:0]      cnt_q;
  // entry valid bits: a popped slot clears, a pushed slot sets
  always_comb begin
    vld_d = vld_q;
    if (pop_i) vld_d[rp_q] = 1'b0;
    if (push_i) vld_d[wp_q] = 1'b1;
  end
  // pointers, occupancy and valid bits
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      wp_q  <= wp_q + AW'(push_i);
      rp_q  <= rp_q + AW'(pop_i);
      cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  end
  // payload storage needs no reset; entries are qualified by vld_q
  always_ff @(posedge clk) begin
    if (push_i) begin
      key_q[wp_q] <= key_i;
      inc_q[wp_q] <= inc_i;
    end
  end
  assign key_o     = key_q[rp_q];
  assign inc_o     = inc_q[rp_q];
  assign empty_o   = cnt_q == '0;
  assign cnt_o     = cnt_q;
  assign ent_vld_o = vld_q;
  assign ent_key_o = key_q;
endmodule

// File: rtl/kvs_upsert.sv
// kvs_upsert: turns (key, inc) updates into kvs lookup/modify/insert; KVS_UPSERT_SAT_EN makes modify saturate
module kvs_upsert
  import kvs_pkg::*;
#(
  parameter int NUM_KEY_BITS = KEY_BITS,
  parameter int NUM_VAL_BITS = VAL_BITS,
  parameter int NUM_PIPES    = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_KEY_BITS-1:0] in_key,
  input  logic [NUM_VAL_BITS-1:0] in_inc,
  output logic                    lookup,
  output logic [NUM_KEY_BITS-1:0] key,
  input  logic                    valid,
  input  logic [NUM_VAL_BITS-1:0] value,
  output logic                    modify,
  output logic                    del,
  output logic [NUM_VAL_BITS-1:0] mod_value,
  input  logic                    busy,
  output logic                    insert,
  output logic [NUM_KEY_BITS-1:0] ins_key,
  output logic [NUM_VAL_BITS-1:0] ins_value,
  output logic                    idle
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic [NUM_PIPES-1:0]    pv_q, pv_d;
  logic [NUM_KEY_BITS-1:0] pk_q [NUM_PIPES];
  logic [NUM_KEY_BITS-1:0] pk_d [NUM_PIPES];
  logic [NUM_VAL_BITS-1:0] pi_q [NUM_PIPES];
  logic [NUM_VAL_BITS-1:0] pi_d [NUM_PIPES];
  logic                    push, q_empty, hazard, credit;
  logic [CW-1:0]           q_cnt;
  logic [FIFO_DEPTH-1:0]   ent_vld;
  logic [NUM_KEY_BITS-1:0] ent_key [FIFO_DEPTH];
  logic [31:0]             inflight;
  // same-key hazard against pipeline and queue, and credit so a miss always finds queue space
  always_comb begin
    hazard   = 1'b0;
    inflight = '0;
    for (int i = 0; i < NUM_PIPES; i++) begin
      hazard   = hazard | (pv_q[i] && pk_q[i] == in_key);
      inflight = inflight + 32'(pv_q[i]);
    end
    for (int j = 0; j < FIFO_DEPTH; j++) hazard = hazard | (ent_vld[j] && ent_key[j] == in_key);
    credit = inflight + 32'(q_cnt) >= 32'(FIFO_DEPTH);
  end
  assign in_ready = !rst && !hazard && !credit;
  assign lookup   = in_valid && in_ready;
  assign key      = in_key;
  assign modify   = !rst && pv_q[0] && valid;
  assign push     = !rst && pv_q[0] && !valid;
  assign insert   = !rst && !q_empty && !busy;
  assign del      = 1'b0;
  assign idle     = !(|pv_q) && q_empty;
`ifdef KVS_UPSERT_SAT_EN
  logic [NUM_VAL_BITS:0] sum;
  assign sum       = {1'b0, value} + {1'b0, pi_q[0]};
  assign mod_value = sum[NUM_VAL_BITS] ? '1 : sum[NUM_VAL_BITS-1:0];
`else
  assign mod_value = value + pi_q[0];
`endif
  // tracking pipeline shifts toward stage 0 every cycle, mirroring the kvs lookup latency
  always_comb begin
    pv_d = '0;
    pk_d = pk_q;
    pi_d = pi_q;
    for (int i = 0; i < NUM_PIPES - 1; i++) begin
      pv_d[i] = pv_q[i+1];
      pk_d[i] = pk_q[i+1];
      pi_d[i] = pi_q[i+1];
    end
    pv_d[NUM_PIPES-1] = lookup;
    pk_d[NUM_PIPES-1] = in_key;
    pi_d[NUM_PIPES-1] = in_inc;
  end
  // stage valids reset so in-flight lookups are dropped
  always_ff @(posedge clk) begin
    if (rst) pv_q <= '0;
    else pv_q <= pv_d;
  end
  // stage payloads are qualified by pv_q
  always_ff @(posedge clk) begin
    pk_q <= pk_d;
    pi_q <= pi_d;
  end
  kvs_ins_fifo #(
    .KW   (NUM_KEY_BITS),
    .VW   (NUM_VAL_BITS),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_i   (push),
    .key_i    (pk_q[0]),
    .inc_i    (pi_q[0]),
    .pop_i    (insert),
    .key_o    (ins_key),
    .inc_o    (ins_value),
    .empty_o  (q_empty),
    .cnt_o    (q_cnt),
    .ent_vld_o(ent_vld),
    .ent_key_o(ent_key)
  );
endmodule
